// File: rtl/mcb_port_bram_responder_if.sv
// MCB-style p0 user port: command, write-data and read-data FIFO handshakes.
// The cache-side controller uses the master view; the BRAM responder uses the slave view.
interface mcb_port_bram_responder_if #(
    parameter int FIFO_AW = 6
);
    logic               calib_done;

    logic               cmd_en;
    logic [2:0]         cmd_instr;
    logic [5:0]         cmd_bl;
    logic [29:0]        cmd_byte_addr;
    logic               cmd_empty;
    logic               cmd_full;

    logic               wr_en;
    logic [15:0]        wr_mask;
    logic [127:0]       wr_data;
    logic               wr_full;
    logic               wr_empty;
    logic [FIFO_AW:0]   wr_count;
    logic               wr_underrun;
    logic               wr_error;

    logic               rd_en;
    logic [127:0]       rd_data;
    logic               rd_full;
    logic               rd_empty;
    logic [FIFO_AW:0]   rd_count;
    logic               rd_overflow;
    logic               rd_error;

    modport master (
        input  calib_done,
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        input  cmd_empty, cmd_full,
        output wr_en, wr_mask, wr_data,
        input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        output rd_en,
        input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
    );

    modport slave (
        output calib_done,
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        output cmd_empty, cmd_full,
        input  wr_en, wr_mask, wr_data,
        output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        input  rd_en,
        output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
    );
endinterface

// File: rtl/mcb_port_bram_responder.sv
// Block-RAM stand-in for the Spartan-6 MCB user port: executes queued write/read
// bursts in order against a 128-bit on-chip memory, for DRAM-less boards and fast sim.
module mcb_port_bram_responder #(
    parameter int MEM_AW    = 10,
    parameter int FIFO_AW   = 6,
    parameter int CMD_AW    = 2,
    parameter int RD_LAT    = 3,
    parameter int CALIB_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    mcb_port_bram_responder_if.slave bus
);
    localparam int FDEPTH = 1 << FIFO_AW;
    localparam int CDEPTH = 1 << CMD_AW;
    localparam int CAL_W  = $clog2(CALIB_CYC + 1);

    typedef enum logic [2:0] {CALIB, IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

    typedef struct packed {
        logic [2:0]        instr;
        logic [5:0]        bl;
        logic [MEM_AW-1:0] idx;
    } cmd_t;

    // ---------------- calibration delay ----------------
    logic [CAL_W-1:0] cal_cnt;
    logic             calib_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_cnt    <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            if (cal_cnt == CAL_W'(CALIB_CYC - 1))
                calib_done <= 1'b1;
            cal_cnt <= cal_cnt + CAL_W'(1);
        end
    end

    // ---------------- command FIFO ----------------
    cmd_t              cmd_mem [CDEPTH];
    cmd_t              cmd_in;
    cmd_t              cmd_head;
    logic [CMD_AW-1:0] cmd_wptr, cmd_rptr;
    logic [CMD_AW:0]   cmd_cnt;
    logic              cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic              unused_addr_bits;

    assign cmd_full  = (cmd_cnt == (CMD_AW+1)'(CDEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_push  = bus.cmd_en && !cmd_full;
    assign cmd_head  = cmd_mem[cmd_rptr];
    assign cmd_in    = '{instr: bus.cmd_instr, bl: bus.cmd_bl,
                         idx: bus.cmd_byte_addr[MEM_AW+3:4]};
    // Sub-word byte offset and address bits above the memory are don't-care.
    assign unused_addr_bits = ^{bus.cmd_byte_addr[3:0], bus.cmd_byte_addr[29:MEM_AW+4]};

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wptr] <= cmd_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            cmd_cnt  <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + CMD_AW'(1);
            if (cmd_pop)  cmd_rptr <= cmd_rptr + CMD_AW'(1);
            cmd_cnt <= cmd_cnt + (CMD_AW+1)'(cmd_push) - (CMD_AW+1)'(cmd_pop);
        end
    end

    // ---------------- write-data FIFO ----------------
    logic [143:0]       wr_mem [FDEPTH];
    logic [FIFO_AW-1:0] wr_wptr, wr_rptr;
    logic [FIFO_AW:0]   wr_cnt;
    logic               wr_full, wr_empty, wr_push, wr_pop;
    logic [127:0]       wr_head_data;
    logic [15:0]        wr_head_mask;

    assign wr_full  = (wr_cnt == (FIFO_AW+1)'(FDEPTH));
    assign wr_empty = (wr_cnt == '0);
    assign wr_push  = bus.wr_en && !wr_full;
    assign {wr_head_mask, wr_head_data} = wr_mem[wr_rptr];

    always_ff @(posedge clk) begin
        if (wr_push)
            wr_mem[wr_wptr] <= {bus.wr_mask, bus.wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_cnt  <= '0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + FIFO_AW'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + FIFO_AW'(1);
            wr_cnt <= wr_cnt + (FIFO_AW+1)'(wr_push) - (FIFO_AW+1)'(wr_pop);
        end
    end

    // ---------------- burst sequencer ----------------
    state_t            state;
    logic [5:0]        cur_bl, beat;
    logic [MEM_AW-1:0] cur_idx;
    logic              wr_go;
    logic [8:0]        wait_cnt;
    logic              wr_underrun, wr_error;
    logic              wr_beat, rd_issue;
    logic [127:0]      last_data, bram_wdata;
    logic [15:0]       last_mask, bram_wmask;
    logic [FIFO_AW:0]  rd_cnt, inflight;
    logic [FIFO_AW+1:0] rd_free;

    assign cmd_pop  = (state == IDLE) && !cmd_empty;
    assign wr_beat  = (state == WR_BURST) && wr_go;
    assign wr_pop   = wr_beat && !wr_empty;
    assign rd_issue = (state == RD_BURST);
    // Slots not yet claimed by stored words or reads still in the pipeline.
    assign rd_free  = (FIFO_AW+2)'(FDEPTH) - {1'b0, rd_cnt} - {1'b0, inflight};

    // On underrun the previously popped word is written again.
    assign bram_wdata = wr_pop ? wr_head_data : last_data;
    assign bram_wmask = wr_pop ? wr_head_mask : last_mask;

    always_ff @(posedge clk) begin
        if (wr_pop) begin
            last_data <= wr_head_data;
            last_mask <= wr_head_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CALIB;
            cur_bl      <= '0;
            beat        <= '0;
            cur_idx     <= '0;
            wr_go       <= 1'b0;
            wait_cnt    <= '0;
            wr_underrun <= 1'b0;
            wr_error    <= 1'b0;
        end else begin
            wr_underrun <= 1'b0;
            if (bus.wr_en && wr_full)
                wr_error <= 1'b1;
            case (state)
                CALIB: begin
                    if (calib_done)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!cmd_empty) begin
                        cur_bl   <= cmd_head.bl;
                        cur_idx  <= cmd_head.idx;
                        beat     <= '0;
                        wr_go    <= 1'b0;
                        wait_cnt <= '0;
                        case (cmd_head.instr)
                            3'b000, 3'b010: state <= WR_BURST;
                            3'b001, 3'b011: state <= RD_WAIT;
                            default:        state <= IDLE;
                        endcase
                    end
                end
                WR_BURST: begin
                    if (!wr_go) begin
                        if (wr_cnt > (FIFO_AW+1)'(cur_bl))
                            wr_go <= 1'b1;
                        else if (wait_cnt == 9'd256)
                            wr_go <= 1'b1;
                        else
                            wait_cnt <= wait_cnt + 9'd1;
                    end else begin
                        if (wr_empty) begin
                            wr_underrun <= 1'b1;
                            wr_error    <= 1'b1;
                        end
                        cur_idx <= cur_idx + MEM_AW'(1);
                        beat    <= beat + 6'd1;
                        if (beat == cur_bl)
                            state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (rd_free > (FIFO_AW+2)'(cur_bl))
                        state <= RD_BURST;
                end
                RD_BURST: begin
                    cur_idx <= cur_idx + MEM_AW'(1);
                    beat    <= beat + 6'd1;
                    if (beat == cur_bl)
                        state <= IDLE;
                end
                default: state <= CALIB;
            endcase
        end
    end

    // ---------------- block RAM ----------------
    logic [127:0] bram [1 << MEM_AW];
    logic [127:0] dat_p [RD_LAT];
    logic         vld_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (wr_beat) begin
            for (int b = 0; b < 16; b++) begin
                if (!bram_wmask[b])
                    bram[cur_idx][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
        end
    end

    // Read pipeline: p0 is the BRAM output register, later stages pad out RD_LAT.
    always_ff @(posedge clk) begin
        if (rd_issue)
            dat_p[0] <= bram[cur_idx];
        for (int k = 1; k < RD_LAT; k++)
            dat_p[k] <= dat_p[k-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++)
                vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= rd_issue;
            for (int k = 1; k < RD_LAT; k++)
                vld_p[k] <= vld_p[k-1];
        end
    end

    // ---------------- read-data FIFO ----------------
    logic [127:0]       rd_mem [FDEPTH];
    logic [FIFO_AW-1:0] rd_wptr, rd_rptr;
    logic               rd_full, rd_empty, rd_push, rd_push_ok, rd_pop;
    logic               rd_overflow, rd_error;

    assign rd_full    = (rd_cnt == (FIFO_AW+1)'(FDEPTH));
    assign rd_empty   = (rd_cnt == '0);
    assign rd_push    = vld_p[RD_LAT-1];
    assign rd_push_ok = rd_push && !rd_full;
    assign rd_pop     = bus.rd_en && !rd_empty;

    always_ff @(posedge clk) begin
        if (rd_push_ok)
            rd_mem[rd_wptr] <= dat_p[RD_LAT-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_wptr     <= '0;
            rd_rptr     <= '0;
            rd_cnt      <= '0;
            inflight    <= '0;
            rd_overflow <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            if (rd_push_ok) rd_wptr <= rd_wptr + FIFO_AW'(1);
            if (rd_pop)     rd_rptr <= rd_rptr + FIFO_AW'(1);
            rd_cnt   <= rd_cnt + (FIFO_AW+1)'(rd_push_ok) - (FIFO_AW+1)'(rd_pop);
            inflight <= inflight + (FIFO_AW+1)'(rd_issue) - (FIFO_AW+1)'(rd_push);
            if (rd_push && rd_full)
                rd_overflow <= 1'b1;
            if (bus.rd_en && rd_empty)
                rd_error <= 1'b1;
        end
    end

    assign bus.calib_done  = calib_done;
    assign bus.cmd_empty   = cmd_empty;
    assign bus.cmd_full    = cmd_full;
    assign bus.wr_full     = wr_full;
    assign bus.wr_empty    = wr_empty;
    assign bus.wr_count    = wr_cnt;
    assign bus.wr_underrun = wr_underrun;
    assign bus.wr_error    = wr_error;
    assign bus.rd_data     = rd_mem[rd_rptr];
    assign bus.rd_full     = rd_full;
    assign bus.rd_empty    = rd_empty;
    assign bus.rd_count    = rd_cnt;
    assign bus.rd_overflow = rd_overflow;
    assign bus.rd_error    = rd_error;
endmodule

// File: tb/tb_mcb_port_bram_responder.sv
// Directed bench for mcb_port_bram_responder: table of single-word masked
// write/readback vectors plus hand-written burst, wrap, underrun and fill sequences.
module tb_mcb_port_bram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edges;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    mcb_port_bram_responder_if #(.FIFO_AW(6)) bus ();

    mcb_port_bram_responder #(
        .MEM_AW(10), .FIFO_AW(6), .CMD_AW(2), .RD_LAT(3), .CALIB_CYC(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [29:0]  addr;
        logic [2:0]   wi;
        logic [2:0]   ri;
        logic [15:0]  mask;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dpat(input int k);
        return {32'(k), 32'hA5A50000 + 32'(k), 32'h5A5A0000 + 32'(k), 32'(k * 3)};
    endfunction

    task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
        bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_mask = m;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
        int n = 0;
        while (bus.cmd_full && n < 1000) begin @(negedge clk); n++; end
        bus.cmd_en = 1'b1; bus.cmd_instr = ins; bus.cmd_bl = bl; bus.cmd_byte_addr = a;
        @(negedge clk);
        bus.cmd_en = 1'b0;
    endtask

    task automatic pop_word(output logic [127:0] d);
        int n = 0;
        while (bus.rd_empty && n < 2000) begin @(negedge clk); n++; end
        if (bus.rd_empty) begin
            checks++; errors++;
            $display("FAIL rd_wait_timeout: got empty expected data");
            d = 'x;
        end else begin
            d = bus.rd_data;
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic wait_rd_count(input int target);
        int n = 0;
        while (int'(bus.rd_count) != target && n < 2000) begin @(negedge clk); n++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        int pulses;
        int n;

        bus.cmd_en = 0; bus.cmd_instr = 0; bus.cmd_bl = 0; bus.cmd_byte_addr = 0;
        bus.wr_en = 0; bus.wr_mask = 0; bus.wr_data = 0; bus.rd_en = 0;

        vecs[0] = '{30'h000, 3'b000, 3'b001, 16'h0000,
                    128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h00112233_44556677_8899AABB_CCDDEEFF};
        vecs[1] = '{30'h000, 3'b000, 3'b001, 16'hFFFE,
                    {16{8'h5A}},                              128'h00112233_44556677_8899AABB_CCDDEE5A};
        vecs[2] = '{30'h010, 3'b010, 3'b011, 16'h0000,
                    128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
        vecs[3] = '{30'h010, 3'b000, 3'b001, 16'hFF00,
                    {16{8'h11}},                              128'hDEADBEEF_CAFEF00D_11111111_11111111};
        vecs[4] = '{30'h01F, 3'b000, 3'b001, 16'hFFFF,
                    128'h0,                                   128'hDEADBEEF_CAFEF00D_11111111_11111111};
        vecs[5] = '{30'h0AB, 3'b000, 3'b011, 16'h0000,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'h0F0E0D0C_0B0A0908_07060504_03020100};
        vecs[6] = '{30'h0A0, 3'b010, 3'b001, 16'h8001,
                    {16{8'hFF}},                              128'h0FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_calib_done", bus.calib_done, 0);
        chk("rst_empties", {bus.cmd_empty, bus.wr_empty, bus.rd_empty}, 3'b111);
        chk("rst_counts", {bus.wr_count, bus.rd_count}, 0);
        chk("rst_errors", {bus.wr_error, bus.rd_error, bus.wr_underrun, bus.rd_overflow}, 0);
        reset = 1'b0;

        // Commands accepted before calibration; fifth is dropped while full
        push_cmd(3'b111, 6'd0, 30'h0);
        push_cmd(3'b100, 6'd0, 30'h0);
        push_cmd(3'b101, 6'd0, 30'h0);
        push_cmd(3'b110, 6'd0, 30'h0);
        chk("precal_cmd_full", bus.cmd_full, 1);
        bus.cmd_en = 1'b1; bus.cmd_instr = 3'b111;
        @(negedge clk);
        bus.cmd_en = 1'b0;
        chk("precal_cmd_empty", bus.cmd_empty, 0);
        while (edges < 63) @(negedge clk);
        chk("calib_low_at_63", bus.calib_done, 0);
        chk("cmd_held_until_calib", bus.cmd_full, 1);
        @(negedge clk);
        chk("calib_high_at_64", bus.calib_done, 1);
        repeat (10) @(negedge clk);
        chk("noops_consumed", bus.cmd_empty, 1);

        // Table: single-word masked write then readback
        for (int i = 0; i < NV; i++) begin
            push_wr(vecs[i].wdata, vecs[i].mask);
            push_cmd(vecs[i].wi, 6'd0, vecs[i].addr);
            push_cmd(vecs[i].ri, 6'd0, vecs[i].addr);
            pop_word(got);
            chk($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // 16-word burst write and readback
        for (int k = 0; k < 16; k++) push_wr(dpat(k), 16'h0);
        chk("wr_count_16", bus.wr_count, 16);
        push_cmd(3'b000, 6'd15, 30'h100);
        push_cmd(3'b001, 6'd15, 30'h100);
        wait_rd_count(16);
        repeat (10) @(negedge clk);
        chk("rd_count_peak_16", bus.rd_count, 16);
        chk("wr_drained", bus.wr_empty, 1);
        for (int k = 0; k < 16; k++) begin
            pop_word(got);
            chk($sformatf("burst_d%0d", k), got, dpat(k));
        end

        // Address wrap at the last word
        push_wr(128'h11112222_33334444_55556666_77778888, 16'h0);
        push_wr(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 16'h0);
        push_cmd(3'b010, 6'd1, 30'h3FF0);
        push_cmd(3'b001, 6'd0, 30'h3FF0);
        push_cmd(3'b001, 6'd0, 30'h0);
        push_cmd(3'b011, 6'd1, 30'h3FF0);
        pop_word(got); chk("wrap_last",  got, 128'h11112222_33334444_55556666_77778888);
        pop_word(got); chk("wrap_idx0",  got, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000);
        pop_word(got); chk("wrap_rd_w0", got, 128'h11112222_33334444_55556666_77778888);
        pop_word(got); chk("wrap_rd_w1", got, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000);

        // Write underrun: bl=3 with only two words supplied
        chk("wr_error_clear", bus.wr_error, 0);
        push_wr(128'hAAAA0000_00000000_00000000_0000AAAA, 16'h0);
        push_wr(128'hBBBB1111_11111111_11111111_1111BBBB, 16'h0);
        push_cmd(3'b000, 6'd3, 30'h200);
        pulses = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.wr_underrun) pulses++;
        end
        chk("underrun_pulses", pulses, 2);
        chk("underrun_wr_error", bus.wr_error, 1);
        push_cmd(3'b001, 6'd3, 30'h200);
        pop_word(got); chk("under_w0", got, 128'hAAAA0000_00000000_00000000_0000AAAA);
        pop_word(got); chk("under_w1", got, 128'hBBBB1111_11111111_11111111_1111BBBB);
        pop_word(got); chk("under_w2", got, 128'hBBBB1111_11111111_11111111_1111BBBB);
        pop_word(got); chk("under_w3", got, 128'hBBBB1111_11111111_11111111_1111BBBB);

        // Fill the read FIFO with four bursts; a fifth read must wait for room
        chk("rd_error_clear", bus.rd_error, 0);
        for (int j = 0; j < 4; j++) push_cmd(3'b001, 6'd15, 30'h100);
        wait_rd_count(64);
        push_cmd(3'b001, 6'd0, 30'h100);
        repeat (30) @(negedge clk);
        chk("fill_rd_count", bus.rd_count, 64);
        chk("fill_rd_full", bus.rd_full, 1);
        chk("fill_cmd_taken", bus.cmd_empty, 1);
        chk("fill_no_overflow", bus.rd_overflow, 0);
        for (int k = 0; k < 64; k++) begin
            pop_word(got);
            chk($sformatf("fill_w%0d", k), got, dpat(k % 16));
        end
        pop_word(got);
        chk("fifth_read", got, dpat(0));
        repeat (10) @(negedge clk);
        chk("drained_empty", bus.rd_empty, 1);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("rd_error_on_empty_pop", bus.rd_error, 1);
        chk("rd_count_still_0", bus.rd_count, 0);
        chk("overflow_never", bus.rd_overflow, 0);

        // Reset during a read burst
        push_cmd(3'b001, 6'd15, 30'h100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {bus.calib_done, bus.cmd_empty, bus.wr_empty, bus.rd_empty}, 4'b0111);
        chk("midrst_errors", {bus.wr_error, bus.rd_error, bus.rd_count}, 0);
        repeat (75) @(negedge clk);
        chk("midrst_recal", bus.calib_done, 1);
        chk("midrst_no_stray_reads", bus.rd_empty, 1);
        push_cmd(3'b001, 6'd0, 30'h100);
        pop_word(got);
        chk("bram_kept_over_reset", got, dpat(0));

        // Overfill the write FIFO, then drain it with a full-length burst
        bus.wr_en = 1'b1;
        for (int k = 0; k < 65; k++) begin
            bus.wr_data = dpat(100 + k); bus.wr_mask = 16'h0;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        chk("wr_full_count", bus.wr_count, 64);
        chk("wr_full_flag", bus.wr_full, 1);
        chk("wr_error_on_full_push", bus.wr_error, 1);
        push_cmd(3'b000, 6'd63, 30'h300);
        n = 0;
        while (!bus.wr_empty && n < 500) begin @(negedge clk); n++; end
        chk("wr_drain_count", bus.wr_count, 0);
        push_cmd(3'b001, 6'd0, 30'h300);
        push_cmd(3'b001, 6'd0, 30'h6F0);
        pop_word(got); chk("full_first_word", got, dpat(100));
        pop_word(got); chk("full_last_word", got, dpat(163));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
